demux: RTL

//  Dataflow demultiplexer: joins one data token with one index token and steers
//  the data to output channel `index`; all other outputs stay idle for that token.

---
 rtl/demux.sv | 81 ++++++++
 1 files changed

// File: rtl/demux.sv
// Handshake demultiplexer: joins a data token with an index token and steers the data to
// output channel `index`, through a one-slot transparent elastic buffer per output.
module demux #(
   parameter int SIZE        = 2,
   parameter int DATA_TYPE   = 32,
   parameter int SELECT_TYPE = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_TYPE-1:0]      ins,
   input  logic                      ins_valid,
   output logic                      ins_ready,
   input  logic [SELECT_TYPE-1:0]    index,
   input  logic                      index_valid,
   output logic                      index_ready,
   output logic [SIZE*DATA_TYPE-1:0] outs,
   output logic [SIZE-1:0]           outs_valid,
   input  logic [SIZE-1:0]           outs_ready,
   output logic                      index_err
);

   localparam logic [SELECT_TYPE:0] SIZE_W = (SELECT_TYPE + 1)'(SIZE);

   logic [SIZE-1:0]      full_q, full_d;
   logic [DATA_TYPE-1:0] data_q [SIZE];
   logic [DATA_TYPE-1:0] data_d [SIZE];
   logic                 index_err_q, index_err_d;
   logic                 sel_ok, slot_rdy, fire;
   logic [SIZE-1:0]      in_v;

   // Join: readiness looks only at the partner channel and the destination slot.
   always_comb begin
      sel_ok   = {1'b0, index} < SIZE_W;
      slot_rdy = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         if (sel_ok && index == SELECT_TYPE'(i)) slot_rdy = ~full_q[i];
      end
      ins_ready   = ~rst & index_valid & slot_rdy;
      index_ready = ~rst & ins_valid & slot_rdy;
      fire        = ~rst & ins_valid & index_valid & slot_rdy;
      for (int i = 0; i < SIZE; i++) begin
         in_v[i] = fire & sel_ok & (index == SELECT_TYPE'(i));
      end
      index_err_d = index_err_q | (fire & ~sel_ok);
   end

   always_comb begin
      outs       = '0;
      outs_valid = '0;
      full_d     = full_q;
      for (int i = 0; i < SIZE; i++) begin
         data_d[i] = data_q[i];
         if (!rst) begin
            outs_valid[i] = full_q[i] | in_v[i];
            outs[i*DATA_TYPE +: DATA_TYPE] = full_q[i] ? data_q[i] : ins;
         end
         // A full slot only drains; an empty one parks a stalled arrival.
         if (full_q[i]) begin
            if (outs_ready[i]) full_d[i] = 1'b0;
         end else if (in_v[i] && !outs_ready[i]) begin
            full_d[i] = 1'b1;
            data_d[i] = ins;
         end
      end
   end

   assign index_err = index_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= '0;
         index_err_q <= 1'b0;
         for (int i = 0; i < SIZE; i++) data_q[i] <= '0;
      end else begin
         full_q      <= full_d;
         index_err_q <= index_err_d;
         for (int i = 0; i < SIZE; i++) data_q[i] <= data_d[i];
      end
   end

endmodule
